mmio_led_pwm: RTL and testbench
===============================

# mmio_led_pwm

Memory-mapped LED/RGB peripheral sitting directly downstream of the `riscv_processor` data-memory port. It decodes processor load/store requests in its address window and drives the board `led`, `red`, `green` and `blue` pins from software-programmable 8-bit PWM duties. It also exposes free-running microsecond and millisecond counters, so firmware can time blinks and fades without busy-loop calibration.

## Interface
- `CLK_HZ`, 12_000_000: system clock frequency. Must be an integer multiple of 1_000_000.
- `ACTIVE_LOW`, 1: when 1, all four pin outputs are inverted (driven 1 = LED off).
- `clk` in 1: system clock. The block uses only this clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: the processor presents a bus access this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 4: byte offset within the window. Bits [1:0] are ignored (word access only).
- `req_wdata` in 32: store data.
- `req_be` in 4: store byte enables.
- `resp_valid` out 1: load data valid.
- `resp_rdata` out 32: load data.
- `led`, `red`, `green`, `blue` out 1 each: PWM pin outputs.

## Operation
- Register map (word offsets):
  - 0x0 DUTY, RW: [7:0] led, [15:8] red, [23:16] green, [31:24] blue.
  - 0x4 PRESCALE, RW, [15:0]. Bits [31:16] read 0.
  - 0x8 MS_COUNT, RO, 32 bits.
  - 0xC US_COUNT, RO, 32 bits.
- Stores:
  - Each byte is written only where `req_be` is set.
  - Stores to RO offsets are silently ignored.
  - There is no store response.
- DUTY write goes to a shadow register. The active duty register loads from the shadow only when the PWM counter wraps from 255 to 0. This gives glitch-free updates.
- PRESCALE write takes effect immediately and clears the prescale counter.
- PWM prescaler:
  - The prescale counter counts 0..PRESCALE. When it equals PRESCALE, the PWM tick asserts and the counter returns to 0.
  - PRESCALE = 0 gives a tick every cycle.
- PWM counter:
  - 8-bit counter that increments on each tick and wraps 255 to 0.
  - Channel is on iff `pwm_cnt < active_duty`. Duty 0 = always off; duty 255 = on 255 of every 256 ticks.
- Pin output = on XOR `ACTIVE_LOW`.
- Time base:
  - The us divider counts 0..CLK_HZ/1e6-1. At the terminal count, US_COUNT increments by 1.
  - Every 1000th microsecond, MS_COUNT increments by 1.
  - Both counters wrap modulo 2^32 and cannot be written.

## Timing
- Load latency is exactly 1 cycle: `resp_valid` pulses high the cycle after `req_valid && !req_we`, with `resp_rdata` valid in that same cycle.
- `resp_rdata` is 0 whenever `resp_valid` is 0.
- Back-to-back loads are supported, one per cycle.
- A store is committed at the edge on which it is presented. A load of the same register in the next cycle returns the new value. For DUTY, this is the shadow value.
- Loads of MS_COUNT/US_COUNT return the value held at the request edge.
- Reset values:
  - DUTY (shadow and active) = 0, PRESCALE = 0, all counters = 0.
  - `resp_valid` = 0, `resp_rdata` = 0.
  - Pins at the inactive level: 1 when `ACTIVE_LOW`=1.
- Reset asserted mid-operation returns everything to these values immediately (asynchronous). A pending load response is dropped.
- DUTY store in the same cycle as the 255→0 wrap: the active register takes the old shadow value; the new value applies at the next wrap.
- PRESCALE store in the same cycle as a tick: the tick still occurs; the counter restarts at 0 with the new PRESCALE.
- us increment and ms increment on the same edge are both applied.

## Structure
- Package `mmio_pkg` holds:
  - The register offset constants `DUTY_OFS`, `PRESCALE_OFS`, `MS_OFS`, `US_OFS`.
  - The `duty_t` packed struct {blue, green, red, led}.
- Sub-module `pwm_channel` (inputs: `pwm_cnt`, 8-bit duty; output: on) is instantiated four times. The prescaler, PWM counter and time base live in the top.

## Test plan
- Reset held, then released: all pins = 1, `resp_valid` = 0; loads of all four offsets return 0.
- Store DUTY = 0x00FF8000 with PRESCALE = 0: blue stays 1 (off), led stays 1, red is 0 (on) for 128 of 256 cycles, green is 0 for 255 of 256 cycles. Active duty changes only at a counter wrap.
- `req_be` = 4'b0010 store of 0xAABBCCDD to DUTY: DUTY reads back 0x0000CC00, 1 cycle later, with a single-cycle `resp_valid`.
- PRESCALE = 3: PWM counter advances every 4 cycles, so the PWM period is 1024 cycles. A store to MS_COUNT is ignored.
- `CLK_HZ` = 12e6, run 12_000 cycles: US_COUNT = 1000, MS_COUNT = 1. The test also forces US_COUNT to 0xFFFFFFFF and checks wrap to 0.
- Assert `rst_n` low mid-PWM-period with a load in flight: outputs go inactive asynchronously, no `resp_valid` is seen, and registers read 0 after release.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared register map and duty layout for the memory-mapped LED/RGB PWM peripheral.
package mmio_pkg;

  localparam logic [3:0] DUTY_OFS     = 4'h0;
  localparam logic [3:0] PRESCALE_OFS = 4'h4;
  localparam logic [3:0] MS_OFS       = 4'h8;
  localparam logic [3:0] US_OFS       = 4'hC;

  typedef struct packed {
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] led;
  } duty_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM comparator: the channel is on while the shared counter is below its duty.
module pwm_channel (
  input  logic [7:0] pwm_cnt,
  input  logic [7:0] duty,
  output logic       on
);

  always_comb begin
    on = (pwm_cnt < duty);
  end

endmodule

// File: rtl/mmio_led_pwm.sv
// LED/RGB PWM peripheral on the processor data bus, with free-running us/ms time base.
module mmio_led_pwm
  import mmio_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned US_DIV  = CLK_HZ / 1_000_000;
  localparam int unsigned DIV_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [DIV_W-1:0] US_LAST = DIV_W'(US_DIV - 1);
  localparam logic [9:0] MS_LAST  = 10'd999;

  duty_t             shadow_q, shadow_d;
  duty_t             active_q, active_d;
  logic [15:0]       prescale_q, prescale_d;
  logic [15:0]       pre_cnt_q, pre_cnt_d;
  logic [7:0]        pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0]  us_div_q, us_div_d;
  logic [9:0]        ms_div_q, ms_div_d;
  logic [31:0]       us_cnt_q, us_cnt_d;
  logic [31:0]       ms_cnt_q, ms_cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [3:0]  word_ofs;
  logic        wr_duty, wr_pre, rd_req;
  logic        tick, wrap, us_tick, ms_tick;
  logic [31:0] rd_word;
  logic        unused_addr_lsb;
  logic        led_on, red_on, green_on, blue_on;

  always_comb begin
    unused_addr_lsb = ^req_addr[1:0];
    word_ofs = {req_addr[3:2], 2'b00};
    wr_duty  = req_valid && req_we && (word_ofs == DUTY_OFS);
    wr_pre   = req_valid && req_we && (word_ofs == PRESCALE_OFS);
    rd_req   = req_valid && !req_we;

    // tick and wrap use pre-store state, so a same-cycle PRESCALE store keeps its
    // tick and a same-cycle DUTY store misses this wrap
    tick    = (pre_cnt_q == prescale_q);
    wrap    = tick && (pwm_cnt_q == 8'hFF);
    us_tick = (us_div_q == US_LAST);
    ms_tick = us_tick && (ms_div_q == MS_LAST);

    shadow_d = wr_duty ? duty_t'(be_merge(shadow_q, req_wdata, req_be)) : shadow_q;
    active_d = wrap ? shadow_q : active_q;

    prescale_d = prescale_q;
    if (wr_pre) begin
      if (req_be[0]) prescale_d[7:0]  = req_wdata[7:0];
      if (req_be[1]) prescale_d[15:8] = req_wdata[15:8];
    end

    if (wr_pre || tick) pre_cnt_d = '0;
    else                pre_cnt_d = pre_cnt_q + 16'd1;
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

    us_div_d = us_tick ? '0 : us_div_q + DIV_W'(1);
    ms_div_d = ms_div_q;
    if (us_tick) ms_div_d = ms_tick ? '0 : ms_div_q + 10'd1;
    us_cnt_d = us_cnt_q + 32'(us_tick);
    ms_cnt_d = ms_cnt_q + 32'(ms_tick);

    case (word_ofs)
      DUTY_OFS:     rd_word = shadow_q;
      PRESCALE_OFS: rd_word = {16'h0000, prescale_q};
      MS_OFS:       rd_word = ms_cnt_q;
      US_OFS:       rd_word = us_cnt_q;
      default:      rd_word = '0;
    endcase
    resp_valid_d = rd_req;
    resp_rdata_d = rd_req ? rd_word : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      active_q     <= '0;
      prescale_q   <= '0;
      pre_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      us_div_q     <= '0;
      ms_div_q     <= '0;
      us_cnt_q     <= '0;
      ms_cnt_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      prescale_q   <= prescale_d;
      pre_cnt_q    <= pre_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      us_div_q     <= us_div_d;
      ms_div_q     <= ms_div_d;
      us_cnt_q     <= us_cnt_d;
      ms_cnt_q     <= ms_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  pwm_channel u_led   (.pwm_cnt(pwm_cnt_q), .duty(active_q.led),   .on(led_on));
  pwm_channel u_red   (.pwm_cnt(pwm_cnt_q), .duty(active_q.red),   .on(red_on));
  pwm_channel u_green (.pwm_cnt(pwm_cnt_q), .duty(active_q.green), .on(green_on));
  pwm_channel u_blue  (.pwm_cnt(pwm_cnt_q), .duty(active_q.blue),  .on(blue_on));

  always_comb begin
    resp_valid = resp_valid_q;
    resp_rdata = resp_rdata_q;
    led        = led_on   ^ ACTIVE_LOW;
    red        = red_on   ^ ACTIVE_LOW;
    green      = green_on ^ ACTIVE_LOW;
    blue       = blue_on  ^ ACTIVE_LOW;
  end

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Scoreboard bench: loads push expected data, a monitor pops on every resp_valid.
module tb_mmio_led_pwm;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        led, red, green, blue;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  mmio_led_pwm #(.CLK_HZ(12_000_000), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid with %h expected no response", resp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, resp_rdata, e.data);
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_store(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    req_be    = be;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.data = exp;
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Active-low pins: a 0 sample means the channel is on.
  task automatic count_on(input int n, output int c_led, output int c_red,
                          output int c_green, output int c_blue);
    c_led = 0; c_red = 0; c_green = 0; c_blue = 0;
    for (int i = 0; i < n; i++) begin
      if (!led)   c_led++;
      if (!red)   c_red++;
      if (!green) c_green++;
      if (!blue)  c_blue++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cl, cr, cg, cb;
    bit found;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    // reset state
    do_reset();
    check("rst_pins", {28'h0, led, red, green, blue}, 32'h0000000F);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    do_load(4'h0, 32'h0, "rst_duty");
    do_load(4'h4, 32'h0, "rst_prescale");
    do_load(4'h8, 32'h0, "rst_ms");
    do_load(4'hC, 32'h0, "rst_us");

    // PWM at PRESCALE=0: no change until the wrap at edge 256
    do_reset();
    do_store(4'h0, 32'h00FF8000, 4'hF);
    count_on(255, cl, cr, cg, cb);
    check("pre_wrap_on_total", 32'(cl + cr + cg + cb), 32'd0);
    count_on(256, cl, cr, cg, cb);
    check("pwm_led_on", 32'(cl), 32'd0);
    check("pwm_red_on", 32'(cr), 32'd128);
    check("pwm_green_on", 32'(cg), 32'd255);
    check("pwm_blue_on", 32'(cb), 32'd0);

    // async reset with a load in flight
    check("green_on_before_rst", 32'(green), 32'h0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pins", {28'h0, led, red, green, blue}, 32'h0000000F);
    check("async_rst_resp_valid", 32'(resp_valid), 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(4'h0, 32'h0, "post_rst_duty");
    do_load(4'h4, 32'h0, "post_rst_prescale");

    // byte-enable store, single-cycle response
    do_store(4'h0, 32'hAABBCCDD, 4'b0010);
    do_load(4'h1, 32'h0000CC00, "be_duty");
    check("be_resp_pulse_hi", 32'(resp_valid), 32'h1);
    @(negedge clk);
    check("be_resp_pulse_lo", 32'(resp_valid), 32'h0);
    check("be_rdata_idle", resp_rdata, 32'h0);

    // PRESCALE=3: ticks at edges 1,2,6,10..., wrap at edge 1018, period 1024
    do_reset();
    do_store(4'h0, 32'h00000100, 4'hF);
    do_store(4'h4, 32'hABCD0003, 4'hF);
    count_on(1016, cl, cr, cg, cb);
    check("ps_red_before_wrap", 32'(cr), 32'd0);
    check("ps_red_first_on", 32'(red), 32'h0);
    count_on(1024, cl, cr, cg, cb);
    check("ps_red_on_period", 32'(cr), 32'd4);
    check("ps_others_on", 32'(cl + cg + cb), 32'd0);
    do_load(4'h4, 32'h00000003, "ps_readback");

    // time base: 12000 cycles at 12 MHz
    do_reset();
    repeat (12000) @(negedge clk);
    do_load(4'hC, 32'd1000, "us_1000");
    do_load(4'h8, 32'd1, "ms_1");
    do_store(4'h8, 32'h12345678, 4'hF);
    do_store(4'hC, 32'h0000DEAD, 4'hF);
    do_load(4'h8, 32'd1, "ms_ro");
    do_load(4'hC, 32'd1000, "us_ro");

    // US_COUNT wrap from all ones
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dut.us_div_q == 0) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("sync_us_div0", 32'(found), 32'h1);
    force dut.us_cnt_q = 32'hFFFF_FFFF;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dut.us_div_q == 4'd11) begin found = 1'b1; break; end
    end
    check("sync_us_div11", 32'(found), 32'h1);
    release dut.us_cnt_q;
    do_load(4'hC, 32'hFFFF_FFFF, "us_max");
    do_load(4'hC, 32'h0, "us_wrap");

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
